// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent programmable timebases. Each channel makes a one-cycle tick strobe
// and a 50%-duty square wave; a new divisor takes effect at a period boundary.
module multi_channel_clock_divider #(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned DIV_W         = 26,
  parameter int unsigned DEFAULT_DIV   = CLK_FREQUENCY / 2,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DIV_W-1:0]  load_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [DIV_W-1:0] DEFAULT_DIV_V = DIV_W'(DEFAULT_DIV);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic [DIV_W-1:0] div_q, div_d;
      logic [DIV_W-1:0] pend_q, pend_d;
      logic             pend_v_q, pend_v_d;
      logic             tick_q, tick_d;
      logic             clk_out_q, clk_out_d;
      logic             load_hit;
      logic             wrap;
      logic [DIV_W-1:0] term;

      // A channel index only matches its own slot, so out-of-range indices never hit.
      assign load_hit = load && (int'(load_ch) == gi);

      // Divisor 0 is treated as 1. The >= compare keeps the count bounded if a
      // smaller divisor was applied while the channel was stopped.
      assign term = (div_q == '0) ? '0 : div_q - DIV_W'(1);
      assign wrap = (cnt_q >= term);

      always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;
        if (sync) begin
          cnt_d     = '0;
          clk_out_d = 1'b0;
          pend_v_d  = 1'b0;
          if (load_hit) begin
            div_d = load_div;
          end else if (pend_v_q) begin
            div_d = pend_q;
          end
        end else begin
          if (en[gi]) begin
            if (wrap) begin
              cnt_d     = '0;
              tick_d    = 1'b1;
              clk_out_d = ~clk_out_q;
            end else begin
              cnt_d = cnt_q + DIV_W'(1);
            end
          end
          // A fresh load always waits for a later boundary, even one landing on a wrap.
          if (load_hit) begin
            pend_d   = load_div;
            pend_v_d = 1'b1;
          end else if (pend_v_q && (wrap || !en[gi])) begin
            div_d    = pend_q;
            pend_v_d = 1'b0;
          end
        end
      end

      always_ff @(posedge clk50) begin
        if (!rst_n) begin
          cnt_q     <= '0;
          div_q     <= DEFAULT_DIV_V;
          pend_q    <= '0;
          pend_v_q  <= 1'b0;
          tick_q    <= 1'b0;
          clk_out_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          div_q     <= div_d;
          pend_q    <= pend_d;
          pend_v_q  <= pend_v_d;
          tick_q    <= tick_d;
          clk_out_q <= clk_out_d;
        end
      end

      assign tick[gi]    = tick_q;
      assign clk_out[gi] = clk_out_q;
    end
  endgenerate

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Bench for multi_channel_clock_divider: directed literal scenarios followed by random
// traffic, all checked every cycle against a per-channel arithmetic model.
module tb_multi_channel_clock_divider;
  // Three channels so that a 2-bit load_ch can address a channel that does not exist.
  localparam int NCH = 3;
  localparam int DW  = 4;
  localparam int CW  = 2;

  logic            clk50 = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  en;
  logic            sync;
  logic            load;
  logic [CW-1:0]   load_ch;
  logic [DW-1:0]   load_div;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  clk_out;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit chk_on = 1'b0;

  int m_cnt[NCH], m_div[NCH], m_pend[NCH];
  bit m_pv[NCH], m_tick[NCH], m_clk[NCH];

  multi_channel_clock_divider #(
    .CLK_FREQUENCY(8), .NUM_CH(NCH), .DIV_W(DW)
  ) dut (
    .clk50(clk50), .rst_n(rst_n), .en(en), .sync(sync), .load(load),
    .load_ch(load_ch), .load_div(load_div), .tick(tick), .clk_out(clk_out)
  );

  always #5 clk50 = ~clk50;

  // Reference model: each channel counts enabled edges; after div_eff of them it
  // strobes and toggles. Divisor changes take effect only at period boundaries.
  always @(posedge clk50) begin
    cycle <= cycle + 1;
    for (int c = 0; c < NCH; c++) begin
      bit hit, wrapped;
      int de;
      hit = load && (int'(load_ch) == c);
      if (!rst_n) begin
        m_cnt[c] = 0; m_div[c] = 4; m_pend[c] = 0;
        m_pv[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
      end else if (sync) begin
        m_cnt[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
        if (hit) m_div[c] = int'(load_div);
        else if (m_pv[c]) m_div[c] = m_pend[c];
        m_pv[c] = 0;
      end else begin
        de = (m_div[c] == 0) ? 1 : m_div[c];
        wrapped = 0;
        m_tick[c] = 0;
        if (en[c]) begin
          if (m_cnt[c] + 1 >= de) begin
            m_cnt[c] = 0; m_tick[c] = 1; m_clk[c] = !m_clk[c]; wrapped = 1;
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end
        if (hit) begin
          m_pend[c] = int'(load_div); m_pv[c] = 1;
        end else if (m_pv[c] && (wrapped || !en[c])) begin
          m_div[c] = m_pend[c]; m_pv[c] = 0;
        end
      end
    end
  end

  always @(negedge clk50) begin
    if (chk_on) begin
      logic [NCH-1:0] et, ec;
      for (int c = 0; c < NCH; c++) begin
        et[c] = m_tick[c];
        ec[c] = m_clk[c];
      end
      checks++;
      if (tick !== et) begin
        errors++;
        $display("FAIL model_tick cycle=%0d actual=%b expected=%b", cycle, tick, et);
      end
      checks++;
      if (clk_out !== ec) begin
        errors++;
        $display("FAIL model_clk_out cycle=%0d actual=%b expected=%b", cycle, clk_out, ec);
      end
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk50);
      @(negedge clk50);
    end
  endtask

  task automatic lit(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic do_load(input int ch, input int dv, input bit with_sync);
    load = 1'b1; load_ch = CW'(ch); load_div = DW'(dv); sync = with_sync;
    cyc();
    load = 1'b0; sync = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = '0; sync = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
    cyc();
    chk_on = 1'b1;
    cyc();
    lit("reset_tick", tick, 3'b000);
    lit("reset_clk_out", clk_out, 3'b000);

    // Release with all channels enabled; load ch1 div=2 on the 2nd edge.
    rst_n = 1'b1; en = 3'b111;
    cyc();
    do_load(1, 2, 1'b0);
    cyc();
    lit("pre_first_tick", tick, 3'b000);
    cyc();
    lit("first_tick", tick, 3'b111);
    lit("first_clk_out", clk_out, 3'b111);
    cyc(2);
    lit("ch1_div2_tick6", tick, 3'b010);
    lit("ch1_div2_clk6", clk_out, 3'b101);
    cyc(2);
    lit("tick8", tick, 3'b111);
    lit("clk8", clk_out, 3'b010);

    // Disable ch0 for three edges: its tick slips from edge 12 to 15.
    en = 3'b110;
    cyc(3);
    en = 3'b111;
    cyc();
    lit("en_gap_tick12", tick, 3'b110);
    cyc(3);
    lit("en_gap_tick15", tick, 3'b001);

    // Sync with a simultaneous load of ch0 div=3.
    do_load(0, 3, 1'b1);
    lit("sync_tick", tick, 3'b000);
    lit("sync_clk_out", clk_out, 3'b000);
    cyc(2);
    lit("sync_plus2", tick, 3'b010);
    cyc();
    lit("sync_plus3", tick, 3'b001);
    cyc();
    lit("sync_plus4", tick, 3'b110);

    // Divisor 0 and divisor 1 both strobe every enabled cycle.
    do_load(0, 0, 1'b1);
    cyc();
    lit("div0_tick_a", {2'b00, tick[0]}, 3'b001);
    lit("div0_clk_a", {2'b00, clk_out[0]}, 3'b001);
    cyc();
    lit("div0_tick_b", {2'b00, tick[0]}, 3'b001);
    lit("div0_clk_b", {2'b00, clk_out[0]}, 3'b000);
    do_load(0, 1, 1'b1);
    cyc();
    lit("div1_tick", {2'b00, tick[0]}, 3'b001);
    lit("div1_clk", {2'b00, clk_out[0]}, 3'b001);

    // Reset with a pending load discards it; out-of-range load_ch changes nothing.
    do_load(2, 1, 1'b0);
    rst_n = 1'b0;
    cyc();
    lit("rst_mid_tick", tick, 3'b000);
    lit("rst_mid_clk", clk_out, 3'b000);
    rst_n = 1'b1;
    do_load(3, 1, 1'b0);
    lit("post_rst_e1", tick, 3'b000);
    cyc(2);
    lit("post_rst_e3", tick, 3'b000);
    cyc();
    lit("post_rst_e4", tick, 3'b111);
    cyc();
    lit("post_rst_e5", tick, 3'b000);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : 3'b111;
      load     = ($urandom_range(0, 3) == 0);
      load_ch  = CW'($urandom_range(0, 3));
      load_div = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 5));
      sync     = ($urandom_range(0, 39) == 0);
      rst_n    = ($urandom_range(0, 149) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
